// File: rtl/calc_op_sequencer.sv
// calc_op_sequencer
// Collects accumulator commands from the front panel (Enter button plus
// switches) and from a host valid/ready port. Arbitrates them round-robin
// into a small command FIFO and issues the head entry to the accumulator
// over a valid/ready handshake. Each button press is either queued exactly
// once or reported through the sticky drop flag.

module calc_op_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pnl_enter,
    input  logic [1:0]               pnl_op,
    input  logic [7:0]               pnl_num,
    input  logic                     hst_valid,
    output logic                     hst_ready,
    input  logic [1:0]               hst_op,
    input  logic [7:0]               hst_num,
    output logic                     iss_valid,
    input  logic                     iss_ready,
    output logic [1:0]               iss_op,
    output logic [7:0]               iss_num,
    input  logic                     flush,
    input  logic                     clr_drop,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     drop_flag
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CMD_W = 10;

    // Round-robin pointer: names the requester that wins a tie
    typedef enum logic {
        RR_PANEL = 1'b0,
        RR_HOST  = 1'b1
    } rr_e;

    // Panel synchronizer and edge detector. These reset to 1 so that an
    // Enter held through reset release does not look like a fresh press.
    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic prv_q, prv_d;

    // Pending panel command waiting for a FIFO slot
    logic [CMD_W-1:0] pend_q, pend_d;
    logic             pnd_v_q, pnd_v_d;

    // Arbitration and status state
    rr_e              rr_q, rr_d;
    logic             drop_q, drop_d;

    // Command FIFO storage: {op[1:0], num[7:0]} per entry
    logic [CMD_W-1:0] mem_q [DEPTH];
    logic [CMD_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Combinational decision signals
    logic             press_s;
    logic             full_s;
    logic             hst_ready_s;
    logic             pnl_grant_s;
    logic             hst_grant_s;
    logic             push_s;
    logic             pop_s;
    logic [CMD_W-1:0] push_data_s;
    logic             drop_evt_s;

    // Synchronizer chain advance and rising-edge detection of Enter
    always_comb begin
        s1_d    = pnl_enter;
        s2_d    = s1_q;
        prv_d   = s2_q;
        press_s = s2_q & ~prv_q;
    end

    // Arbitration: at most one FIFO write per cycle, flush blocks all traffic.
    // A full FIFO refuses writes even when the head pops in the same cycle.
    always_comb begin
        full_s      = (cnt_q == CNT_W'(DEPTH));
        hst_ready_s = ~full_s & (~pnd_v_q | (rr_q == RR_HOST));
        pnl_grant_s = pnd_v_q & ~full_s & (~hst_valid | (rr_q == RR_PANEL)) & ~flush;
        hst_grant_s = hst_valid & hst_ready_s & ~flush;
        push_s      = pnl_grant_s | hst_grant_s;
        pop_s       = (cnt_q != {CNT_W{1'b0}}) & iss_ready & ~flush;
        if (pnl_grant_s) begin
            push_data_s = pend_q;
        end else begin
            push_data_s = {hst_op, hst_num};
        end
    end

    // Pending panel register: capture on press, drop a press that finds the
    // register still occupied and not draining this cycle
    always_comb begin
        pend_d     = pend_q;
        pnd_v_d    = pnd_v_q;
        drop_evt_s = 1'b0;
        if (flush) begin
            pnd_v_d = 1'b0;
        end else if (press_s) begin
            if (pnd_v_q & ~pnl_grant_s) begin
                drop_evt_s = 1'b1;
            end else begin
                pend_d  = {pnl_op, pnl_num};
                pnd_v_d = 1'b1;
            end
        end else if (pnl_grant_s) begin
            pnd_v_d = 1'b0;
        end else begin
            pnd_v_d = pnd_v_q;
        end
    end

    // Round-robin update and sticky drop flag (a same-cycle drop beats clear)
    always_comb begin
        rr_d   = rr_q;
        drop_d = drop_q;
        if (pnl_grant_s) begin
            rr_d = RR_HOST;
        end else if (hst_grant_s) begin
            rr_d = RR_PANEL;
        end else begin
            rr_d = rr_q;
        end
        if (drop_evt_s) begin
            drop_d = 1'b1;
        end else if (clr_drop) begin
            drop_d = 1'b0;
        end else begin
            drop_d = drop_q;
        end
    end

    // FIFO storage write, pointer advance and occupancy count
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            cnt_d    = {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                mem_d[wr_ptr_q] = push_data_s;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // State registers; reset aborts any queued or pending command at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= 1'b1;
            s2_q     <= 1'b1;
            prv_q    <= 1'b1;
            pend_q   <= {CMD_W{1'b0}};
            pnd_v_q  <= 1'b0;
            rr_q     <= RR_PANEL;
            drop_q   <= 1'b0;
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {CMD_W{1'b0}};
            end
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            prv_q    <= prv_d;
            pend_q   <= pend_d;
            pnd_v_q  <= pnd_v_d;
            rr_q     <= rr_d;
            drop_q   <= drop_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            mem_q    <= mem_d;
        end
    end

    assign hst_ready  = hst_ready_s;
    assign iss_valid  = (cnt_q != {CNT_W{1'b0}});
    assign iss_op     = mem_q[rd_ptr_q][9:8];
    assign iss_num    = mem_q[rd_ptr_q][7:0];
    assign fifo_count = cnt_q;
    assign drop_flag  = drop_q;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Directed testbench for calc_op_sequencer. A queue-based command model
// predicts the outputs every cycle; directed tests pin it with literals.

module tb_calc_op_sequencer;

    logic       clk;
    logic       rst_n;
    logic       pnl_enter;
    logic [1:0] pnl_op;
    logic [7:0] pnl_num;
    logic       hst_valid;
    logic       hst_ready;
    logic [1:0] hst_op;
    logic [7:0] hst_num;
    logic       iss_valid;
    logic       iss_ready;
    logic [1:0] iss_op;
    logic [7:0] iss_num;
    logic       flush;
    logic       clr_drop;
    logic [2:0] fifo_count;
    logic       drop_flag;

    int checks   = 0;
    int failures = 0;

    calc_op_sequencer #(.DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .pnl_enter(pnl_enter), .pnl_op(pnl_op),
        .pnl_num(pnl_num), .hst_valid(hst_valid), .hst_ready(hst_ready),
        .hst_op(hst_op), .hst_num(hst_num), .iss_valid(iss_valid),
        .iss_ready(iss_ready), .iss_op(iss_op), .iss_num(iss_num),
        .flush(flush), .clr_drop(clr_drop), .fifo_count(fifo_count),
        .drop_flag(drop_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [9:0] mq[$];          // queued commands, head at index 0
    bit         mp_v;           // panel command waiting for a slot
    logic [9:0] mp;
    bit         m_turn_host;    // host wins the next tie
    bit         m_drop;
    bit [2:0]   hist;           // Enter samples, [0] newest

    always @(posedge clk or negedge rst_n) begin : model
        bit full_m, hrdy_m, pg_m, hg_m, press_m, drop_m;
        if (!rst_n) begin
            mq.delete();
            mp_v = 1'b0;
            mp = 10'h000;
            m_turn_host = 1'b0;
            m_drop = 1'b0;
            hist = 3'b111;
        end else begin
            // press seen when Enter sampled two edges ago was high and three edges ago low
            press_m = hist[1] && !hist[2];
            hist = {hist[1:0], pnl_enter};
            full_m = (mq.size() == 4);
            hrdy_m = !full_m && (!mp_v || m_turn_host);
            pg_m = mp_v && !full_m && (!hst_valid || !m_turn_host);
            hg_m = hst_valid && hrdy_m;
            if (flush) begin
                mq.delete();
                mp_v = 1'b0;
                if (clr_drop) m_drop = 1'b0;
            end else begin
                if (mq.size() != 0 && iss_ready) void'(mq.pop_front());
                if (pg_m) mq.push_back(mp);
                else if (hg_m) mq.push_back({hst_op, hst_num});
                drop_m = press_m && mp_v && !pg_m;
                if (press_m && !drop_m) begin
                    mp = {pnl_op, pnl_num};
                    mp_v = 1'b1;
                end else if (pg_m) begin
                    mp_v = 1'b0;
                end
                if (clr_drop) m_drop = 1'b0;
                if (drop_m) m_drop = 1'b1;
                if (pg_m) m_turn_host = 1'b1;
                else if (hg_m) m_turn_host = 1'b0;
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        chk("m_iss_valid", 32'(iss_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("m_iss_cmd", 32'({iss_op, iss_num}), 32'(mq[0]));
        end
        chk("m_fifo_count", 32'(fifo_count), 32'(mq.size()));
        chk("m_drop_flag", 32'(drop_flag), 32'(m_drop));
        chk("m_hst_ready", 32'(hst_ready), 32'((mq.size() != 4) && (!mp_v || m_turn_host)));
    end

    // Log of commands the DUT actually handed to the accumulator
    logic [9:0] log_q[$];
    always @(posedge clk) begin
        if (rst_n && iss_valid && iss_ready && !flush) log_q.push_back({iss_op, iss_num});
    end

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic host_cmd(input logic [1:0] op, input logic [7:0] num);
        hst_op = op; hst_num = num; hst_valid = 1'b1;
        @(negedge clk);
        hst_valid = 1'b0;
    endtask

    task automatic pulse_enter;
        pnl_enter = 1'b1; cyc(2);
        pnl_enter = 1'b0; cyc(3);
    endtask

    initial begin
        rst_n = 1'b1; pnl_enter = 1'b0; pnl_op = 2'd0; pnl_num = 8'h00;
        hst_valid = 1'b0; hst_op = 2'd0; hst_num = 8'h00; iss_ready = 1'b0;
        flush = 1'b0; clr_drop = 1'b0;
        #1 rst_n = 1'b0;
        cyc(3);
        chk("rst_iss_valid", 32'(iss_valid), 32'd0);
        chk("rst_fifo_count", 32'(fifo_count), 32'd0);
        chk("rst_hst_ready", 32'(hst_ready), 32'd1);
        chk("rst_drop_flag", 32'(drop_flag), 32'd0);
        chk("rst_iss_cmd", 32'({iss_op, iss_num}), 32'd0);
        #2 rst_n = 1'b1;

        // Host single command
        @(negedge clk);
        iss_ready = 1'b1;
        host_cmd(2'd0, 8'h05);
        chk("t1_valid", 32'(iss_valid), 32'd1);
        chk("t1_num", 32'(iss_num), 32'h05);
        chk("t1_op", 32'(iss_op), 32'd0);
        @(negedge clk);
        chk("t1_valid_gone", 32'(iss_valid), 32'd0);
        chk("t1_count", 32'(fifo_count), 32'd0);
        chk("t1_log_n", 32'(log_q.size()), 32'd1);
        if (log_q.size() > 0) chk("t1_log0", 32'(log_q[0]), 32'h005);

        // Panel press, Enter held 10 cycles
        log_q.delete();
        pnl_op = 2'd1; pnl_num = 8'h03; cyc(2);
        pnl_enter = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("t2_latency", 32'(iss_valid), 32'(k == 3));
        end
        pnl_enter = 1'b0; cyc(4);
        chk("t2_log_n", 32'(log_q.size()), 32'd1);
        if (log_q.size() > 0) chk("t2_log0", 32'(log_q[0]), 32'h103);

        // Full FIFO
        log_q.delete();
        iss_ready = 1'b0;
        hst_op = 2'd0; hst_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            hst_num = 8'h10 + 8'(i);
            @(negedge clk);
        end
        chk("t3_full_count", 32'(fifo_count), 32'd4);
        chk("t3_full_ready", 32'(hst_ready), 32'd0);
        hst_num = 8'h14;
        @(negedge clk);
        chk("t3_still_full", 32'(fifo_count), 32'd4);
        iss_ready = 1'b1;
        @(negedge clk);
        chk("t3_pop_no_push", 32'(fifo_count), 32'd3);
        @(negedge clk);
        hst_valid = 1'b0;
        chk("t3_push_pop", 32'(fifo_count), 32'd3);
        cyc(6);
        chk("t3_log_n", 32'(log_q.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (log_q.size() > i) chk("t3_order", 32'(log_q[i]), 32'h010 + 32'(i));
        end

        // Contention: pending panel vs held host
        log_q.delete();
        pnl_op = 2'd0; pnl_num = 8'h55; cyc(2);
        pnl_enter = 1'b1;
        cyc(3);
        hst_op = 2'd2; hst_num = 8'hAA; hst_valid = 1'b1;
        chk("t4_host_blocked", 32'(hst_ready), 32'd0);
        @(negedge clk);
        chk("t4_host_turn", 32'(hst_ready), 32'd1);
        @(negedge clk);
        hst_valid = 1'b0;
        pnl_enter = 1'b0;
        cyc(5);
        chk("t4_log_n", 32'(log_q.size()), 32'd2);
        if (log_q.size() > 1) begin
            chk("t4_first", 32'(log_q[0]), 32'h055);
            chk("t4_second", 32'(log_q[1]), 32'h2AA);
        end

        // Drop, clear and flush
        iss_ready = 1'b0;
        for (int i = 0; i < 4; i++) host_cmd(2'd3, 8'h20 + 8'(i));
        pnl_op = 2'd1; pnl_num = 8'h31; cyc(2);
        pulse_enter();
        chk("t5_no_drop_yet", 32'(drop_flag), 32'd0);
        pnl_num = 8'h32; cyc(2);
        pulse_enter();
        chk("t5_drop", 32'(drop_flag), 32'd1);
        chk("t5_count", 32'(fifo_count), 32'd4);
        clr_drop = 1'b1; @(negedge clk); clr_drop = 1'b0;
        chk("t5_clr", 32'(drop_flag), 32'd0);
        flush = 1'b1; @(negedge clk); flush = 1'b0;
        chk("t5_flush_count", 32'(fifo_count), 32'd0);
        chk("t5_flush_valid", 32'(iss_valid), 32'd0);
        chk("t5_flush_ready", 32'(hst_ready), 32'd1);

        // Reset in the middle of operation with Enter held
        log_q.delete();
        for (int i = 0; i < 3; i++) host_cmd(2'd0, 8'h40 + 8'(i));
        pnl_num = 8'h77;
        pnl_enter = 1'b1;
        cyc(3);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(iss_valid), 32'd0);
        chk("t6_rst_count", 32'(fifo_count), 32'd0);
        chk("t6_rst_ready", 32'(hst_ready), 32'd1);
        chk("t6_rst_drop", 32'(drop_flag), 32'd0);
        chk("t6_rst_cmd", 32'({iss_op, iss_num}), 32'd0);
        cyc(2);
        #2 rst_n = 1'b1;
        iss_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("t6_no_issue", 32'(iss_valid), 32'd0);
        end
        pnl_enter = 1'b0; cyc(3);
        chk("t6_log_empty", 32'(log_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/calc_op_sequencer.md
# calc_op_sequencer

Command sequencer for the 8-bit accumulator calculator datapath. It collects operations from two requesters, the front-panel switches with the Enter button and a host valid/ready port, and arbitrates them round-robin into a 4-entry command FIFO. It then issues one command at a time to the accumulator over a valid/ready handshake, so button presses and host commands are never applied twice and never lost silently.

## Interface
- DEPTH, 4, command FIFO entries (power of two; the count width is log2(DEPTH)+1)
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- pnl_enter  in  1  raw Enter button level, asynchronous to clk
- pnl_op  in  2  panel opcode: 0 add, 1 sub, 2 or, 3 eq (quasi-static switches)
- pnl_num  in  8  panel operand (quasi-static switches)
- hst_valid  in  1  host command valid
- hst_ready  out  1  host command accepted when hst_valid & hst_ready
- hst_op  in  2  host opcode, same encoding as pnl_op
- hst_num  in  8  host operand
- iss_valid  out  1  a command is presented to the accumulator
- iss_ready  in  1  accumulator accepts the command this cycle
- iss_op  out  2  opcode of the FIFO head
- iss_num  out  8  operand of the FIFO head
- flush  in  1  synchronous; discards the FIFO and any pending panel command
- clr_drop  in  1  synchronous; clears drop_flag
- fifo_count  out  3  occupied FIFO entries, 0..4
- drop_flag  out  1  sticky; a panel press was discarded

## Operation
- Panel path: pnl_enter passes through a 2-flop synchronizer (s1, s2), then an edge register (prv).
  - s1, s2 and prv reset to 1, so an Enter held through reset release produces no request.
  - press = s2 & ~prv.
  - On press, {pnl_op, pnl_num} is captured into the pend register and pnd_v is set.
  - If a press arrives while pnd_v=1 and pend is not written to the FIFO in the same cycle, the press is discarded and drop_flag is set.
- Arbitration: at most one FIFO write per cycle. Candidates are the panel (pnd_v) and the host (hst_valid).
  - The rr bit gives priority. It resets to panel.
  - After a panel grant, rr points to host. After a host grant, rr points to panel.
  - Writes are allowed only when fifo_count < DEPTH. A full FIFO never accepts a write, even when a pop happens in the same cycle.
  - hst_ready = ~full & (~pnd_v | rr==host). It must not depend on hst_valid.
  - The panel is granted when pnd_v & ~full & (~hst_valid | rr==panel). The grant clears pnd_v, unless a new press reloads pend in the same cycle.
- FIFO: circular buffer with wrapping read and write pointers.
  - iss_valid = (fifo_count != 0).
  - iss_op and iss_num come from the head entry and are stable while iss_valid is high and no pop occurs.
  - A pop occurs when iss_valid & iss_ready.
  - A simultaneous push and pop leaves fifo_count unchanged.
- flush takes priority over every push and pop in its cycle.
  - It empties the FIFO and clears pnd_v.
  - It does not change drop_flag or rr.
- clr_drop clears drop_flag. A drop in the same cycle wins, so drop_flag stays 1.
- Reset values:
  - Outputs: iss_valid=0, iss_op=0, iss_num=0, fifo_count=0, drop_flag=0, hst_ready=1.
  - Internal state: pointers 0, pnd_v=0, rr=panel.

## Timing
- Panel latency for a rising edge of pnl_enter first sampled high at edge E0:
  - s2=1 after E1.
  - press is high in the cycle after E1.
  - pend is loaded at E2.
  - The earliest FIFO write is at E3.
  - iss_valid rises after E3 (4 edges total).
- Host latency: a transfer at edge E is visible on iss_valid after E (1 cycle).
- Throughput: one push and one pop per cycle. Sustained host plus panel traffic alternates grants.
- A pop at edge E exposes the next entry immediately after E. There is no bubble.
- Operands are not synchronized. The panel switches must be stable for 2 cycles before Enter.
- Reset asserted mid-transfer aborts the transfer immediately. No partial command is ever issued.

## Test plan
- Host single command: hst op=0 num=5, iss_ready=1 -> iss_valid for exactly 1 cycle with op=0, num=0x05, 1 cycle after the transfer; fifo_count returns to 0.
- Panel press: op=1 num=3, Enter high for 10 cycles -> exactly one issue of {1, 0x03}, with iss_valid rising 4 edges after the first sample; no repeat while Enter stays high.
- Full FIFO: iss_ready=0, 5 host commands (0x10..0x14) -> fifo_count=4 and hst_ready=0 after the 4th; set iss_ready=1 -> issue order 0x10..0x13, then 0x14.
- Contention: hst_valid held with num=0xAA while the panel presses num=0x55 -> panel is granted first (rr reset), then host; issue order 0x55, 0xAA.
- Drop: FIFO full, two panel presses -> second press discarded and drop_flag=1; clr_drop -> 0; flush -> fifo_count=0 and iss_valid=0 on the next cycle.
- Reset mid-operation: 3 entries queued, Enter held, rst_n pulsed low -> all outputs at reset values; after release, no issue occurs while Enter stays high.
